// File: rtl/chip8_bcd_store.sv
// Sequential executor for Chip-8 FX33: latches Vx/I, samples the external BCD
// converter, then writes hundreds/tens/ones to I, I+1, I+2 through one write port.
module chip8_bcd_store #(
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        vx,
   input  logic [15:0]       index,
   output logic [7:0]        bcd_num,
   input  logic [3:0]        bcd_hundreds,
   input  logic [3:0]        bcd_tens,
   input  logic [3:0]        bcd_ones,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              mem_we,
   input  logic              mem_grant,
   output logic              busy,
   output logic              done
);

   typedef enum logic [2:0] {
      IDLE,
      CONV,
      WR_H,
      WR_T,
      WR_O,
      DONE
   } state_t;

   state_t            state_q, state_d;
   logic [7:0]        op_q, op_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [3:0]        hund_q, hund_d;
   logic [3:0]        tens_q, tens_d;
   logic [3:0]        ones_q, ones_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   // Upper I-register bits are deliberately discarded; addresses wrap in 4 KiB.
   logic unused_index_bits;
   assign unused_index_bits = ^index[15:ADDR_W];

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      base_d  = base_q;
      hund_d  = hund_q;
      tens_d  = tens_q;
      ones_d  = ones_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               op_d    = vx;
               base_d  = index[ADDR_W-1:0];
               state_d = CONV;
            end
         end
         CONV: begin
            hund_d  = bcd_hundreds;
            tens_d  = bcd_tens;
            ones_d  = bcd_ones;
            state_d = WR_H;
         end
         WR_H:    if (mem_grant) state_d = WR_T;
         WR_T:    if (mem_grant) state_d = WR_O;
         WR_O:    if (mem_grant) state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Outputs are decoded from the next state so they register alongside it.
      we_d    = 1'b0;
      addr_d  = '0;
      wdata_d = '0;
      case (state_d)
         WR_H: begin
            we_d    = 1'b1;
            addr_d  = base_d;
            wdata_d = {4'h0, hund_d};
         end
         WR_T: begin
            we_d    = 1'b1;
            addr_d  = base_d + ADDR_W'(1);
            wdata_d = {4'h0, tens_d};
         end
         WR_O: begin
            we_d    = 1'b1;
            addr_d  = base_d + ADDR_W'(2);
            wdata_d = {4'h0, ones_d};
         end
         default: ;
      endcase
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= '0;
         base_q  <= '0;
         hund_q  <= '0;
         tens_q  <= '0;
         ones_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         base_q  <= base_d;
         hund_q  <= hund_d;
         tens_q  <= tens_d;
         ones_q  <= ones_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign bcd_num   = op_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_we    = we_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_chip8_bcd_store.sv
// Directed bench for chip8_bcd_store: table of FX33 operations plus stall,
// ignored-start and mid-operation reset sequences.
module tb_chip8_bcd_store;
   localparam int ADDR_W = 12;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              start = 1'b0;
   logic [7:0]        vx = 8'h00;
   logic [15:0]       index = 16'h0000;
   logic              mem_grant = 1'b1;
   logic [7:0]        bcd_num;
   logic [3:0]        bcd_hundreds, bcd_tens, bcd_ones;
   logic [ADDR_W-1:0] mem_addr;
   logic [7:0]        mem_wdata;
   logic              mem_we, busy, done;

   int passed = 0;
   int total  = 0;
   int done_cnt = 0;
   logic [11:0] wq_addr[$];
   logic [7:0]  wq_data[$];

   typedef struct {
      logic [7:0]  vx;
      logic [15:0] idx;
      logic [11:0] a0, a1, a2;
      logic [7:0]  d0, d1, d2;
      string       tag;
   } vec_t;
   vec_t vecs[6];

   chip8_bcd_store #(.ADDR_W(ADDR_W)) dut (
      .clk(clk), .reset(reset), .start(start), .vx(vx), .index(index),
      .bcd_num(bcd_num), .bcd_hundreds(bcd_hundreds), .bcd_tens(bcd_tens),
      .bcd_ones(bcd_ones), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_we(mem_we), .mem_grant(mem_grant), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Combinational binary-to-decimal converter sitting upstream of the DUT
   always_comb begin
      bcd_hundreds = 4'(bcd_num / 100);
      bcd_tens     = 4'((bcd_num / 10) % 10);
      bcd_ones     = 4'(bcd_num % 10);
   end

   always @(negedge clk) begin
      if (!reset && mem_we && mem_grant) begin
         wq_addr.push_back(mem_addr);
         wq_data.push_back(mem_wdata);
      end
      if (!reset && done) done_cnt++;
   end

   task automatic chk(input string tag, input string what,
                      input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s %s: got %0h, want %0h", tag, what, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_wr(input string tag, input logic [11:0] a, input logic [7:0] d);
      chk(tag, "we",   32'(mem_we),    32'd1);
      chk(tag, "addr", 32'(mem_addr),  32'(a));
      chk(tag, "data", 32'(mem_wdata), 32'(d));
      chk(tag, "busy", 32'(busy),      32'd1);
   endtask

   task automatic do_op(input logic [7:0] v, input logic [15:0] idx,
                        input logic [11:0] a0, input logic [11:0] a1, input logic [11:0] a2,
                        input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                        input string tag);
      int n0 = wq_addr.size();
      int dc0 = done_cnt;
      start = 1'b1; vx = v; index = idx;
      tick();
      start = 1'b0; vx = ~v; index = ~idx;
      chk(tag, "conv busy", 32'(busy), 32'd1);
      chk(tag, "conv we", 32'(mem_we), 32'd0);
      chk(tag, "bcd_num", 32'(bcd_num), 32'(v));
      tick(); chk_wr({tag, " H"}, a0, d0);
      tick(); chk_wr({tag, " T"}, a1, d1);
      tick(); chk_wr({tag, " O"}, a2, d2);
      tick();
      chk(tag, "done", 32'(done), 32'd1);
      chk(tag, "done we", 32'(mem_we), 32'd0);
      tick();
      chk(tag, "idle busy", 32'(busy), 32'd0);
      chk(tag, "idle done", 32'(done), 32'd0);
      chk(tag, "op persists", 32'(bcd_num), 32'(v));
      chk(tag, "write count", 32'(wq_addr.size() - n0), 32'd3);
      chk(tag, "done count", 32'(done_cnt - dc0), 32'd1);
   endtask

   task automatic chk_all_zero(input string tag);
      chk(tag, "bcd_num", 32'(bcd_num), 32'd0);
      chk(tag, "addr", 32'(mem_addr), 32'd0);
      chk(tag, "wdata", 32'(mem_wdata), 32'd0);
      chk(tag, "we", 32'(mem_we), 32'd0);
      chk(tag, "busy", 32'(busy), 32'd0);
      chk(tag, "done", 32'(done), 32'd0);
   endtask

   initial begin
      int n0;
      int dc0;
      vecs[0] = '{8'hFE, 16'h0300, 12'h300, 12'h301, 12'h302, 8'd2, 8'd5, 8'd4, "vx254"};
      vecs[1] = '{8'h00, 16'h0200, 12'h200, 12'h201, 12'h202, 8'd0, 8'd0, 8'd0, "vx0"};
      vecs[2] = '{8'h09, 16'h0200, 12'h200, 12'h201, 12'h202, 8'd0, 8'd0, 8'd9, "vx9"};
      vecs[3] = '{8'h7B, 16'h0FFE, 12'hFFE, 12'hFFF, 12'h000, 8'd1, 8'd2, 8'd3, "wrap"};
      vecs[4] = '{8'h7B, 16'hF123, 12'h123, 12'h124, 12'h125, 8'd1, 8'd2, 8'd3, "highidx"};
      vecs[5] = '{8'hFF, 16'h0FFF, 12'hFFF, 12'h000, 12'h001, 8'd2, 8'd5, 8'd5, "vx255wrap"};

      #2 reset = 1'b1;
      #1 chk_all_zero("reset");
      tick(); tick();
      chk_all_zero("reset clocked");
      reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++)
         do_op(vecs[i].vx, vecs[i].idx, vecs[i].a0, vecs[i].a1, vecs[i].a2,
               vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].tag);

      for (int v = 0; v < 256; v++)
         do_op(8'(v), 16'h0200, 12'h200, 12'h201, 12'h202,
               8'(v / 100), 8'((v / 10) % 10), 8'(v % 10), $sformatf("sweep%0d", v));

      // Grant withheld for three cycles while the tens write is pending
      n0 = wq_addr.size(); dc0 = done_cnt;
      start = 1'b1; vx = 8'd77; index = 16'h0200;
      tick(); start = 1'b0;
      tick(); chk_wr("stall H", 12'h200, 8'd0);
      tick(); chk_wr("stall T0", 12'h201, 8'd7); mem_grant = 1'b0;
      tick(); chk_wr("stall T1", 12'h201, 8'd7);
      tick(); chk_wr("stall T2", 12'h201, 8'd7);
      tick(); chk_wr("stall T3", 12'h201, 8'd7); mem_grant = 1'b1;
      tick(); chk_wr("stall O", 12'h202, 8'd7);
      tick(); chk("stall", "done N+8", 32'(done), 32'd1);
      tick(); chk("stall", "idle", 32'(busy), 32'd0);
      chk("stall", "write count", 32'(wq_addr.size() - n0), 32'd3);
      chk("stall", "tens addr", 32'(wq_addr[n0 + 1]), 32'h201);
      chk("stall", "tens data", 32'(wq_data[n0 + 1]), 32'd7);
      chk("stall", "ones addr", 32'(wq_addr[n0 + 2]), 32'h202);

      // Extra start pulses in CONV and DONE must be dropped
      n0 = wq_addr.size(); dc0 = done_cnt;
      start = 1'b1; vx = 8'hFE; index = 16'h0300;
      tick(); vx = 8'h11; index = 16'h0500;
      tick(); start = 1'b0; chk_wr("ign H", 12'h300, 8'd2);
      tick(); chk_wr("ign T", 12'h301, 8'd5);
      tick(); chk_wr("ign O", 12'h302, 8'd4);
      tick(); chk("ign", "done", 32'(done), 32'd1);
      start = 1'b1; vx = 8'h11; index = 16'h0500;
      tick(); start = 1'b0;
      chk("ign", "start in DONE busy", 32'(busy), 32'd0);
      chk("ign", "op kept", 32'(bcd_num), 32'hFE);
      tick();
      chk("ign", "still idle", 32'(busy), 32'd0);
      chk("ign", "no write", 32'(mem_we), 32'd0);
      chk("ign", "write count", 32'(wq_addr.size() - n0), 32'd3);
      chk("ign", "done count", 32'(done_cnt - dc0), 32'd1);

      // Reset during the tens write aborts the operation
      n0 = wq_addr.size(); dc0 = done_cnt;
      start = 1'b1; vx = 8'd77; index = 16'h0200;
      tick(); start = 1'b0;
      tick(); chk_wr("rst H", 12'h200, 8'd0);
      tick(); chk_wr("rst T", 12'h201, 8'd7);
      reset = 1'b1;
      #1 chk_all_zero("mid reset");
      tick(); tick();
      reset = 1'b0;
      tick(); tick(); tick(); tick();
      chk("rst", "idle after", 32'(busy), 32'd0);
      chk("rst", "write count", 32'(wq_addr.size() - n0), 32'd1);
      chk("rst", "done count", 32'(done_cnt - dc0), 32'd0);
      do_op(8'h7B, 16'h0FFE, 12'hFFE, 12'hFFF, 12'h000, 8'd1, 8'd2, 8'd3, "after reset");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/chip8_bcd_store.md
# chip8_bcd_store

Sequential executor for the Chip-8 FX33 instruction (store BCD of Vx at I, I+1, I+2). It sits directly downstream of the combinational `bcd` converter. It latches the operand, drives the converter's `num` input, and captures the hundreds/tens/ones digits. It then writes them as three bytes into the 4 KiB Chip-8 memory through a single write port, with a start/done handshake toward the CPU control FSM.

## Interface
- ADDR_W, 12: memory address width (4 KiB Chip-8 space).
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- vx  in  8  operand value; sampled with start.
- index  in  16  I register; sampled with start; only [ADDR_W-1:0] used.
- bcd_num  out  8  operand driven to the `bcd` converter.
- bcd_hundreds  in  4  converter hundreds digit.
- bcd_tens  in  4  converter tens digit.
- bcd_ones  in  4  converter ones digit.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  8  write data; digit zero-extended to 8 bits.
- mem_we  out  1  write strobe.
- mem_grant  in  1  arbiter grant; a write completes only in a cycle with mem_we=1 and mem_grant=1.
- busy  out  1  high from the cycle after accepted start through DONE inclusive.
- done  out  1  one-cycle pulse after the third write completes.

## Operation
- FSM states: IDLE, CONV, WR_H, WR_T, WR_O, DONE.
- IDLE, start=1:
  - latch vx into op_reg and index[ADDR_W-1:0] into base_reg.
  - go to CONV.
- IDLE, start=0: stay.
- CONV:
  - bcd_num = op_reg.
  - capture bcd_hundreds/tens/ones into digit registers at the end of the cycle.
  - go to WR_H.
- WR_H: mem_we=1, mem_addr=base_reg, mem_wdata={4'h0,hundreds}.
  - mem_grant=1: go to WR_T.
  - mem_grant=0: hold state and outputs.
- WR_T: as WR_H, with addr=base_reg+1 and tens; advance to WR_O on grant.
- WR_O: as WR_H, with addr=base_reg+2 and ones; advance to DONE on grant.
- DONE: done=1, busy=1, mem_we=0; go to IDLE unconditionally.
- Address arithmetic is modulo 2^ADDR_W:
  - base 0xFFF gives addresses 0xFFF, 0x000, 0x001.
  - index bits above ADDR_W-1 are ignored.
- bcd_num holds op_reg in every state. op_reg persists after completion; reset value is 0.
- start while busy (CONV..DONE) is ignored and not queued.
- start in the same cycle as DONE is ignored; DONE is not IDLE.
- vx and index changing after acceptance have no effect.
- Digit registers come from the converter combinationally. Values are 0–9 for hundreds/tens/ones except hundreds, which is 0–2. No range checking is performed.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE; op_reg, base_reg and digits = 0.
  - bcd_num=0, mem_addr=0, mem_wdata=0, mem_we=0, busy=0, done=0.
- Reset asserted mid-operation aborts at once:
  - no further writes are issued.
  - writes already granted remain in memory.
  - done is not pulsed.
- All outputs are registered or decoded from registered state. No combinational path from start, mem_grant or bcd inputs to any output.
- With mem_grant held at 1 and start accepted at edge N:
  - CONV in cycle N+1.
  - writes in cycles N+2, N+3, N+4.
  - done in cycle N+5.
  - IDLE at N+6, where a new start is accepted.
- Minimum turnaround is 6 cycles start-to-start.
- Each cycle of mem_grant=0 during a write state adds exactly one cycle. The address and data for that write stay stable until granted.
- mem_we is never high outside WR_H/WR_T/WR_O. Exactly three granted writes occur per uninterrupted operation, in the order hundreds, tens, ones.

## Test plan
- vx=0xFE (254), index=0x300, grant=1:
  - writes (0x300,2), (0x301,5), (0x302,4) in cycles N+2..N+4.
  - done at N+5.
- vx=0x00 and vx=0x09, index=0x200: writes 0,0,0 and 0,0,9 respectively. All 256 vx values are checked against expected decimal digits.
- vx=123, index=0xFFE:
  - writes at 0xFFE, 0xFFF, 0x000 with 1, 2, 3.
  - index=0xF123 writes at 0x123..0x125.
- vx=77, grant low 3 cycles during WR_T: addr 0x201 / data 7 held for 4 cycles, exactly one tens write counted, done at N+8.
- start pulsed again in CONV and in DONE with a different vx: ignored, and only the original three writes occur.
- reset asserted during WR_T:
  - all outputs read 0 the same cycle.
  - no WR_O write and no done.
  - a fresh start after reset release completes normally.
